piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 115 +++++++++++
 tb/tb_piso_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load and gapless back-to-back frames.
// Optional even-parity trailer beat is compiled in with `define PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             out_q;
  logic             accept;
  logic             final_beat;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] first_rest, next_rest;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par;
`endif

  assign final_beat = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    case (state)
      IDLE:    load_ready = !reset;
      SHIFT:   load_ready = !reset && (cnt == LAST);
      default: load_ready = 1'b0;
    endcase
    accept = load_valid && load_ready;
    if (accept)
      state_nxt = SHIFT;
    else if (final_beat)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The first beat comes straight from the captured word; later beats shift out of shreg.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign first_bit  = data[WIDTH-1];
      assign first_rest = {data[WIDTH-2:0], 1'b0};
      assign next_bit   = shreg[WIDTH-1];
      assign next_rest  = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign first_bit  = data[0];
      assign first_rest = {1'b0, data[WIDTH-1:1]};
      assign next_bit   = shreg[0];
      assign next_rest  = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
      out_q <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      shreg <= first_rest;
      cnt   <= '0;
      out_q <= first_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= ^data;
`endif
    end else if (final_beat) begin
      shreg <= '0;
      cnt   <= '0;
      out_q <= 1'b0;
    end else if (state == SHIFT) begin
      cnt   <= cnt + CW'(1);
      shreg <= next_rest;
      out_q <= next_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
      // Parity trails the data bits whatever the bit order.
      if (cnt == CW'(WIDTH - 1))
        out_q <= par;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign done      = final_beat;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an MSB-first and an LSB-first instance share one stimulus stream.
// Expected beats are queued at each modelled accept edge and popped one per cycle on the falling edge.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data;
  logic         load_valid;
  logic         lr_m, out_m, ov_m, busy_m, done_m;
  logic         lr_l, out_l, ov_l, busy_l, done_l;

  beat_t qm[$];
  beat_t ql[$];
  beat_t cur_m, cur_l;
  logic  have_m = 1'b0, have_l = 1'b0;
  logic  started = 1'b0;

  logic [15:0] cap_m = '0, cap_l = '0;
  logic [15:0] frame_m = '0, frame_l = '0;
  int          done_cnt = 0;
  int          checks = 0;
  int          passes = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .data(data), .load_valid(load_valid),
    .load_ready(lr_m), .out(out_m), .out_valid(ov_m), .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .data(data), .load_valid(load_valid),
    .load_ready(lr_l), .out(out_l), .out_valid(ov_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else
      passes++;
  endtask

  task automatic checkLane(input string tag, input logic o, input logic ov, input logic bs,
                           input logic dn, input logic lr, input logic have, input beat_t cur);
    logic exp_ready;
    exp_ready = !reset && (!have || cur.last);
    checkOutput({tag, "_out"},        {15'd0, o},  {15'd0, have ? cur.b : 1'b0});
    checkOutput({tag, "_out_valid"},  {15'd0, ov}, {15'd0, have});
    checkOutput({tag, "_busy"},       {15'd0, bs}, {15'd0, have});
    checkOutput({tag, "_done"},       {15'd0, dn}, {15'd0, have && cur.last});
    checkOutput({tag, "_load_ready"}, {15'd0, lr}, {15'd0, exp_ready});
  endtask

  task automatic pushFrame(input logic [W-1:0] d);
    beat_t bm, bl;
    for (int k = 0; k < W; k++) begin
      bm.b = d[W-1-k];
      bm.last = (k == L - 1);
      bl.b = d[k];
      bl.last = (k == L - 1);
      qm.push_back(bm);
      ql.push_back(bl);
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    bm.b = ^d;
    bm.last = 1'b1;
    qm.push_back(bm);
    ql.push_back(bm);
`endif
  endtask

  // Reference model: accept decisions and expected beats, evaluated at every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      qm.delete();
      ql.delete();
    end else if (started && load_valid && (!have_m || cur_m.last)) begin
      pushFrame(data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      have_m = (qm.size() > 0);
      cur_m  = have_m ? qm.pop_front() : '0;
      have_l = (ql.size() > 0);
      cur_l  = have_l ? ql.pop_front() : '0;
      checkLane("msb", out_m, ov_m, busy_m, done_m, lr_m, have_m, cur_m);
      checkLane("lsb", out_l, ov_l, busy_l, done_l, lr_l, have_l, cur_l);
      if (ov_m === 1'b1) cap_m = {cap_m[14:0], out_m};
      else               cap_m = '0;
      if (ov_l === 1'b1) cap_l = {cap_l[14:0], out_l};
      else               cap_l = '0;
      if (done_m === 1'b1) begin
        frame_m = cap_m;
        cap_m   = '0;
        done_cnt++;
      end
      if (done_l === 1'b1) begin
        frame_l = cap_l;
        cap_l   = '0;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r, input int cycles);
    load_valid = v;
    data       = d;
    reset      = r;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  int dc0;
  logic [W-1:0] w;

  initial begin
    // Reset with load_valid high: it must be ignored.
    applyStimulus(1'b1, 8'hB4, 1'b1, 2);
    applyStimulus(1'b0, 8'hB4, 1'b0, 5);

    // Single frame, then change data while not loading.
    applyStimulus(1'b1, 8'hB4, 1'b0, 1);
    applyStimulus(1'b0, 8'h5A, 1'b0, L + 2);
`ifdef PISO_SERIALIZER_PARITY_EN
    checkOutput("msb_b4_seq", frame_m, 16'b1_0110_1000);
    checkOutput("lsb_b4_seq", frame_l, 16'b0_0101_1010);
`else
    checkOutput("msb_b4_seq", frame_m, 16'b1011_0100);
    checkOutput("lsb_b4_seq", frame_l, 16'b0010_1101);
`endif

    // 0x07 exercises an odd-parity word.
    applyStimulus(1'b1, 8'h07, 1'b0, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, L + 2);
`ifdef PISO_SERIALIZER_PARITY_EN
    checkOutput("msb_07_seq", frame_m, 16'b0_0000_1111);
    checkOutput("lsb_07_seq", frame_l, 16'b1_1100_0001);
`else
    checkOutput("msb_07_seq", frame_m, 16'b0000_0111);
    checkOutput("lsb_07_seq", frame_l, 16'b1110_0000);
`endif

    // Back-to-back: 0xFF then 0x00 accepted on the final beat.
    dc0 = done_cnt;
    applyStimulus(1'b1, 8'hFF, 1'b0, 1);
    applyStimulus(1'b1, 8'h00, 1'b0, L);
    applyStimulus(1'b0, 8'h00, 1'b0, L + 2);
    checkOutput("b2b_done_pulses", 16'(done_cnt - dc0), 16'd2);
    checkOutput("b2b_second_frame", frame_m, 16'h0000);

    // Reset asserted while beat 3 is on the line aborts the frame.
    dc0 = done_cnt;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1);
    applyStimulus(1'b0, 8'hA5, 1'b0, 3);
    applyStimulus(1'b0, 8'hA5, 1'b1, 1);
    applyStimulus(1'b0, 8'hA5, 1'b0, 2);
    checkOutput("abort_no_done", 16'(done_cnt - dc0), 16'd0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1);
    applyStimulus(1'b0, 8'h3C, 1'b0, L + 2);
`ifdef PISO_SERIALIZER_PARITY_EN
    checkOutput("msb_3c_seq", frame_m, 16'b0_0111_1000);
`else
    checkOutput("msb_3c_seq", frame_m, 16'b0011_1100);
`endif

    // A short burst of random back-to-back words.
    w = W'($urandom);
    applyStimulus(1'b1, w, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      w = W'($urandom);
      applyStimulus(1'b1, w, 1'b0, L);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, L + 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
